// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencer: PC, valid/ack memory port, output register, redirects
module fetch_ctrl #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic [1:0]       PCsrc,
  input  logic [WIDTH-1:0] branch_pc,
  input  logic [WIDTH-1:0] ImmOp,
  input  logic [WIDTH-1:0] RegIn,
  input  logic             stall,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic             instr_valid,
  output logic [WIDTH-1:0] PC,
  output logic             misaligned
);

  typedef enum logic [1:0] {IDLE, REQ, DRAIN, HALT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] instr_q;
  logic [WIDTH-1:0] instr_pc_q;
  logic [WIDTH-1:0] tgt_q;
  logic             instr_valid_q;
  logic             kill_q;
  logic             misaligned_q;

  logic             redirect;
  logic [WIDTH-1:0] jalr_sum;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] jump_addr;
  logic             jump_bad;
  state_t           jump_state;

  // Redirect decode; a live redirect beats a held one, otherwise REQ replays the held target
  always_comb begin
    redirect   = (PCsrc == 2'b01) || (PCsrc == 2'b10);
    jalr_sum   = RegIn + ImmOp;
    target     = (PCsrc == 2'b10) ? {jalr_sum[WIDTH-1:1], 1'b0} : (branch_pc + ImmOp);
    jump_addr  = (state_q == REQ && !redirect) ? tgt_q : target;
    jump_bad   = jump_addr[1];
    jump_state = jump_bad ? HALT : REQ;
  end

  // Request is issued in REQ, and in DRAIN whenever the held instruction is consumed without a flush
  always_comb begin
    imem_req = 1'b0;
    case (state_q)
      REQ:     imem_req = 1'b1;
      DRAIN:   imem_req = !stall && !redirect;
      default: imem_req = 1'b0;
    endcase
  end

  // Fetch sequencer: PC, held redirect, output register and sticky misalignment flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      kill_q        <= 1'b0;
      tgt_q         <= '0;
      misaligned_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q <= REQ;
          if (redirect) begin
            pc_q         <= jump_addr;
            state_q      <= jump_state;
            misaligned_q <= misaligned_q | jump_bad;
          end
        end
        REQ: begin
          if (imem_ack) begin
            if (redirect || kill_q) begin
              pc_q         <= jump_addr;
              kill_q       <= 1'b0;
              state_q      <= jump_state;
              misaligned_q <= misaligned_q | jump_bad;
            end else begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              pc_q          <= pc_q + WIDTH'(4);
              state_q       <= DRAIN;
            end
          end else if (redirect) begin
            kill_q <= 1'b1;
            tgt_q  <= target;
          end
        end
        DRAIN: begin
          if (redirect) begin
            instr_valid_q <= 1'b0;
            pc_q          <= jump_addr;
            state_q       <= jump_state;
            misaligned_q  <= misaligned_q | jump_bad;
          end else if (!stall) begin
            if (imem_ack) begin
              instr_q    <= imem_rdata;
              instr_pc_q <= pc_q;
              pc_q       <= pc_q + WIDTH'(4);
            end else begin
              instr_valid_q <= 1'b0;
              state_q       <= REQ;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem_addr   = pc_q;
  assign PC          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign misaligned  = misaligned_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - self-checking bench for fetch_ctrl
module tb_fetch_ctrl;
  localparam int W = 32;
  localparam logic [31:0] SALT = 32'hDEAD_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          imem_req;
  logic [W-1:0]  imem_addr;
  logic          imem_ack;
  logic [W-1:0]  imem_rdata;
  logic [1:0]    PCsrc;
  logic [W-1:0]  branch_pc, ImmOp, RegIn;
  logic          stall;
  logic [W-1:0]  instr, instr_pc, PC;
  logic          instr_valid, misaligned;

  int checks = 0;
  int failures = 0;

  assign imem_rdata = imem_addr ^ SALT;

  fetch_ctrl #(.WIDTH(W), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .PCsrc(PCsrc),
    .branch_pc(branch_pc), .ImmOp(ImmOp), .RegIn(RegIn), .stall(stall),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .PC(PC), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a fetch pointer, one output slot and an optional pending jump
  bit          m_started, m_dead, m_full, m_kill, m_err;
  logic [31:0] m_pc, m_tgt, m_slot_pc, m_slot_instr;

  task automatic m_jump(input logic [31:0] a);
    m_pc = a;
    if (a[1]) begin
      m_dead = 1; m_err = 1; m_full = 0;
    end
  endtask

  task automatic m_deliver();
    m_slot_pc    = m_pc;
    m_slot_instr = m_pc ^ SALT;
    m_full       = 1;
    m_pc         = m_pc + 32'd4;
  endtask

  always @(posedge clk or posedge rst) begin
    logic [31:0] t;
    bit r;
    if (rst) begin
      m_started = 0; m_dead = 0; m_full = 0; m_kill = 0; m_err = 0;
      m_pc = 0; m_tgt = 0; m_slot_pc = 0; m_slot_instr = 0;
    end else begin
      r = (PCsrc == 2'b01) || (PCsrc == 2'b10);
      t = (PCsrc == 2'b01) ? branch_pc + ImmOp : ((RegIn + ImmOp) & 32'hFFFF_FFFE);
      if (!m_started) begin
        m_started = 1;
        if (r) m_jump(t);
      end else if (m_dead) begin
      end else if (!m_full) begin
        if (imem_ack) begin
          if (r) begin m_kill = 0; m_jump(t); end
          else if (m_kill) begin m_kill = 0; m_jump(m_tgt); end
          else m_deliver();
        end else if (r) begin
          m_kill = 1; m_tgt = t;
        end
      end else begin
        if (r) begin m_full = 0; m_jump(t); end
        else if (!stall) begin
          if (imem_ack) m_deliver();
          else m_full = 0;
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    bit r, exp_req;
    if (!rst) begin
      r = (PCsrc == 2'b01) || (PCsrc == 2'b10);
      exp_req = m_started && !m_dead && (!m_full || (!stall && !r));
      chk("m_imem_req", imem_req, exp_req);
      chk("m_imem_addr", imem_addr, m_pc);
      chk("m_PC", PC, m_pc);
      chk("m_instr_valid", instr_valid, m_full);
      chk("m_misaligned", misaligned, m_err);
      if (m_full) begin
        chk("m_instr", instr, m_slot_instr);
        chk("m_instr_pc", instr_pc, m_slot_pc);
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; PCsrc = 0; branch_pc = 0; ImmOp = 0; RegIn = 0; stall = 0; imem_ack = 1;
    step(2);
    chk("rst_req", imem_req, 0);
    chk("rst_pc", PC, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_mis", misaligned, 0);
    rst = 0;
    step(1);
    chk("first_req", imem_req, 1);
    chk("first_valid", instr_valid, 0);
    step(1);
    chk("stream0_valid", instr_valid, 1);
    chk("stream0_pc", instr_pc, 32'h0);
    chk("stream0_instr", instr, 32'hDEAD_0000);
    chk("stream0_PC", PC, 32'h4);
    step(1);
    chk("stream1_pc", instr_pc, 32'h4);
    chk("stream1_PC", PC, 32'h8);
    // wait states at 0x8
    imem_ack = 0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, 32'h8);
      chk("wait_valid", instr_valid, 0);
    end
    imem_ack = 1;
    step(1);
    chk("wait_done_pc", instr_pc, 32'h8);
    chk("wait_done_valid", instr_valid, 1);
    step(1);
    chk("pre_stall_pc", instr_pc, 32'hC);
    // stall
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("stall_req", imem_req, 0);
      chk("stall_pc", instr_pc, 32'hC);
      chk("stall_instr", instr, 32'hDEAD_000C);
      step(1);
    end
    stall = 0;
    #1;
    chk("unstall_req", imem_req, 1);
    chk("unstall_addr", imem_addr, 32'h10);
    step(1);
    chk("unstall_pc", instr_pc, 32'h10);
    // late redirect while waiting at 0x14
    imem_ack = 0;
    step(1);
    chk("late_addr0", imem_addr, 32'h14);
    PCsrc = 2'b01; branch_pc = 32'h10; ImmOp = 32'h20;
    step(1);
    PCsrc = 2'b00;
    chk("late_addr1", imem_addr, 32'h14);
    chk("late_req1", imem_req, 1);
    step(1);
    chk("late_addr2", imem_addr, 32'h14);
    imem_ack = 1;
    step(1);
    chk("late_discard_valid", instr_valid, 0);
    chk("late_new_addr", imem_addr, 32'h30);
    chk("late_new_req", imem_req, 1);
    step(1);
    chk("late_fetch_pc", instr_pc, 32'h30);
    // jalr from DRAIN
    PCsrc = 2'b10; RegIn = 32'h101; ImmOp = 32'h4;
    #1;
    chk("jalr_req_low", imem_req, 0);
    step(1);
    PCsrc = 2'b00;
    chk("jalr_flush", instr_valid, 0);
    chk("jalr_addr", imem_addr, 32'h104);
    // misaligned jalr
    PCsrc = 2'b10; RegIn = 32'h102; ImmOp = 32'h0;
    step(1);
    PCsrc = 2'b00;
    chk("mis_flag", misaligned, 1);
    chk("mis_pc", PC, 32'h102);
    chk("mis_req", imem_req, 0);
    step(5);
    chk("halt_req", imem_req, 0);
    chk("halt_flag", misaligned, 1);
    rst = 1;
    #1;
    chk("halt_rst_mis", misaligned, 0);
    chk("halt_rst_pc", PC, 0);
    step(1);
    rst = 0;
    step(3);
    chk("restream_pc", instr_pc, 32'h4);
    imem_ack = 0;
    step(1);
    chk("midreq_addr", imem_addr, 32'h8);
    chk("midreq_req", imem_req, 1);
    // asynchronous reset mid-REQ
    #1 rst = 1;
    #1;
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_instr", instr, 0);
    chk("arst_instr_pc", instr_pc, 0);
    chk("arst_valid", instr_valid, 0);
    step(1);
    rst = 0;
    // redirect during IDLE
    PCsrc = 2'b01; branch_pc = 32'h40; ImmOp = 32'h8; imem_ack = 1;
    step(1);
    PCsrc = 2'b00;
    chk("idle_redir_addr", imem_addr, 32'h48);
    step(1);
    chk("idle_redir_pc", instr_pc, 32'h48);
    // PC wrap
    PCsrc = 2'b01; branch_pc = 32'hFFFF_FFF0; ImmOp = 32'hC;
    step(1);
    PCsrc = 2'b00;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    step(1);
    chk("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_PC", PC, 32'h0);
    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
